// File: rtl/wb_slave_arbiter.sv
// Two-master / one-slave Wishbone arbiter: round-robin, grant held for the whole cyc, stall watchdog.
// Optional grant statistics counters when WB_SLAVE_ARBITER_STATS_EN is defined.
module wb_slave_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o,
`ifdef WB_SLAVE_ARBITER_STATS_EN
    output logic [15:0] gnt0_cnt_o,
    output logic [15:0] gnt1_cnt_o,
`endif
    output logic        timeout_o
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam int unsigned CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_t        state;
    logic          last;
    logic [CW-1:0] wd_cnt;
    logic          wd_fire;
    logic          act_cyc;
    logic          act_stb;
    logic          req0;
    logic          req1;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    always_comb begin
        act_cyc = 1'b0;
        act_stb = 1'b0;
        case (state)
            GNT0: begin
                act_cyc = m0_cyc_i;
                act_stb = m0_stb_i;
            end
            GNT1: begin
                act_cyc = m1_cyc_i;
                act_stb = m1_stb_i;
            end
            default: ;
        endcase
    end

    // A real slave ack in the same cycle wins over the watchdog.
    assign wd_fire = WD_EN && act_stb && !s_ack_i && (wd_cnt == WD_LAST);

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        case (state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~wd_fire;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i | wd_fire;
                m0_dat_o = wd_fire ? TIMEOUT_DATA : s_dat_i;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~wd_fire;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i | wd_fire;
                m1_dat_o = wd_fire ? TIMEOUT_DATA : s_dat_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (wd_fire)
                timeout_o <= 1'b1;
            if (!act_cyc || !act_stb || s_ack_i || wd_fire)
                wd_cnt <= '0;
            else if (wd_cnt != WD_LAST)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Leaving a grant always passes through IDLE, giving one dead cycle between owners.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            grant_o <= 2'b00;
`ifdef WB_SLAVE_ARBITER_STATS_EN
            gnt0_cnt_o <= '0;
            gnt1_cnt_o <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || last)) begin
                        state   <= GNT0;
                        grant_o <= 2'b01;
`ifdef WB_SLAVE_ARBITER_STATS_EN
                        if (gnt0_cnt_o != 16'hFFFF)
                            gnt0_cnt_o <= gnt0_cnt_o + 16'd1;
`endif
                    end else if (req1) begin
                        state   <= GNT1;
                        grant_o <= 2'b10;
`ifdef WB_SLAVE_ARBITER_STATS_EN
                        if (gnt1_cnt_o != 16'hFFFF)
                            gnt1_cnt_o <= gnt1_cnt_o + 16'd1;
`endif
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i) begin
                        state   <= IDLE;
                        last    <= 1'b0;
                        grant_o <= 2'b00;
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i) begin
                        state   <= IDLE;
                        last    <= 1'b1;
                        grant_o <= 2'b00;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= 2'b00;
                end
            endcase
        end
    end

endmodule
